// File: rtl/sprite_blit_arbiter.sv
// Round-robin sprite-ROM blit arbiter: four requesters share one fixed-latency ROM port.
// Optional build macro SPRITE_BLIT_TRANSPARENT_EN suppresses pixels equal to TRANSPARENT_KEY.
module sprite_blit_arbiter #(
  parameter int unsigned ROM_STRIDE      = 1024,
  parameter int unsigned ROM_LAT         = 2,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [47:0] req_x,
  input  logic [47:0] req_y,
  input  logic [47:0] req_w,
  input  logic [47:0] req_h,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        rom_en,
  output logic [23:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [11:0] pix_col,
  output logic [11:0] pix_row,
  output logic [3:0]  done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_last, r_owner, w_win, w_idx;
  logic        w_any;
  logic [5:0]  w_base;
  logic [11:0] r_x0, r_y0, r_w, r_h, r_col, r_row;
  logic        r_zero;
  logic [2:0]  r_drain;
  logic        w_row_end, w_last_px;
  logic [12:0] w_row_abs, w_col_abs;

  logic        r_pv [ROM_LAT];
  logic [11:0] r_pc [ROM_LAT];
  logic [11:0] r_pr [ROM_LAT];
  logic        w_pv_raw, w_keep;

  // Rotating priority: search begins just after the last completed owner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_last + 2'd1 + 2'(k);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_base    = 6'(w_win) * 6'd12;
  assign w_row_end = (r_col == r_w - 12'd1);
  assign w_last_px = w_row_end && (r_row == r_h - 12'd1);
  assign w_row_abs = {1'b0, r_y0} + {1'b0, r_row};
  assign w_col_abs = {1'b0, r_x0} + {1'b0, r_col};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = STREAM;
      STREAM:  if (r_zero) w_next = DONE;
               else if (w_last_px) w_next = DRAIN;
      DRAIN:   if (r_drain == 3'(ROM_LAT - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rom_en   = (r_state == STREAM) && !r_zero;
    rom_addr = '0;
    if (rom_en)
      rom_addr = 24'(w_row_abs) * 24'(ROM_STRIDE) + 24'(w_col_abs);
    busy  = (r_state != IDLE);
    grant = ((r_state == STREAM) || (r_state == DRAIN)) ? (4'b0001 << r_owner) : '0;
    done  = (r_state == DONE) ? (4'b0001 << r_owner) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last  <= 2'd3;
      r_owner <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_zero  <= 1'b0;
      r_drain <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_win;
          r_x0    <= req_x[w_base +: 12];
          r_y0    <= req_y[w_base +: 12];
          r_w     <= req_w[w_base +: 12];
          r_h     <= req_h[w_base +: 12];
          r_zero  <= (req_w[w_base +: 12] == '0) || (req_h[w_base +: 12] == '0);
          r_col   <= '0;
          r_row   <= '0;
          r_drain <= '0;
        end
        STREAM: if (!r_zero) begin
          if (w_row_end) begin
            r_col <= '0;
            r_row <= r_row + 12'd1;
          end else begin
            r_col <= r_col + 12'd1;
          end
        end
        DRAIN: r_drain <= r_drain + 3'd1;
        DONE: begin
          r_last <= r_owner;
          r_col  <= '0;
          r_row  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Strobe and coordinates travel alongside the ROM so they line up with rom_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pc[i] <= '0;
        r_pr[i] <= '0;
      end
    end else begin
      r_pv[0] <= rom_en;
      r_pc[0] <= r_col;
      r_pr[0] <= r_row;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pr[i] <= r_pr[i-1];
      end
    end
  end

  assign w_pv_raw = r_pv[ROM_LAT-1];

`ifdef SPRITE_BLIT_TRANSPARENT_EN
  assign w_keep = (rom_data != TRANSPARENT_KEY);
`else
  logic w_unused_key;
  assign w_unused_key = ^TRANSPARENT_KEY;
  assign w_keep       = 1'b1;
`endif

  assign pix_valid = w_pv_raw & w_keep;
  assign pix_data  = w_pv_raw ? rom_data : '0;
  assign pix_col   = r_pc[ROM_LAT-1];
  assign pix_row   = r_pr[ROM_LAT-1];

endmodule

// File: tb/tb_sprite_blit_arbiter.sv
// Directed bench for sprite_blit_arbiter with a latency-2 ROM model.
// Transparency expectations follow SPRITE_BLIT_TRANSPARENT_EN as defined for the build.
module tb_sprite_blit_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [47:0] req_x = '0, req_y = '0, req_w = '0, req_h = '0;
  logic [3:0]  grant, done;
  logic        busy, rom_en, pix_valid;
  logic [23:0] rom_addr;
  logic [15:0] rom_data, pix_data;
  logic [11:0] pix_col, pix_row;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_blit_arbiter #(
    .ROM_STRIDE(1024),
    .ROM_LAT(LAT),
    .TRANSPARENT_KEY(16'hF81F)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .grant(grant), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_col(pix_col), .pix_row(pix_row), .done(done)
  );

  // ROM contents: first four words form a small test pattern, the rest echo the address.
  function automatic logic [15:0] rom_fn(input logic [23:0] a);
    case (a)
      24'd0:   return 16'h0001;
      24'd1:   return 16'hF81F;
      24'd2:   return 16'h0003;
      24'd3:   return 16'hF81F;
      default: return a[15:0];
    endcase
  endfunction

  logic [15:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= rom_en ? rom_fn(rom_addr) : 16'h0000;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rom_data = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_geom(input int i, input logic [11:0] x, input logic [11:0] y,
                          input logic [11:0] w, input logic [11:0] h);
    req_x[12*i +: 12] = x;
    req_y[12*i +: 12] = y;
    req_w[12*i +: 12] = w;
    req_h[12*i +: 12] = h;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_en"},    32'(rom_en), 32'd0);
    chk({tag, "_addr"},  32'(rom_addr), 32'd0);
    chk({tag, "_pv"},    32'(pix_valid), 32'd0);
    chk({tag, "_pdata"}, 32'(pix_data), 32'd0);
    chk({tag, "_pcol"},  32'(pix_col), 32'd0);
    chk({tag, "_prow"},  32'(pix_row), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && grant == 4'b0000; i++) tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done == 4'b0000; i++) tick();
  endtask

  task automatic zero_blit(input int idx, input logic [11:0] w, input logic [11:0] h,
                           input logic [3:0] g);
    set_geom(idx, 12'd1, 12'd1, w, h);
    req = g;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("zero_en",    32'(rom_en), 32'd0);
      chk("zero_pv",    32'(pix_valid), 32'd0);
      chk("zero_grant", 32'(grant), (c == 1) ? 32'(g) : 32'd0);
      chk("zero_done",  32'(done), (c == 2) ? 32'(g) : 32'd0);
      chk("zero_busy",  32'(busy), 32'(c <= 2));
      if (c == 2) req = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned addrs [6];
    int          npv;
    logic        e_pv;
    logic [3:0]  g;
    addrs = '{5130, 5131, 5132, 6154, 6155, 6156};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;

    // Single 3x2 blit at (10,5)
    set_geom(0, 12'd10, 12'd5, 12'd3, 12'd2);
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t1_en", 32'(rom_en), 32'(c <= 6));
      if (c <= 6) chk("t1_addr", 32'(rom_addr), addrs[c-1]);
      e_pv = (c >= 3) && (c <= 8);
      chk("t1_pv", 32'(pix_valid), 32'(e_pv));
      if (e_pv) begin
        chk("t1_col",  32'(pix_col), 32'((c - 3) % 3));
        chk("t1_row",  32'(pix_row), 32'((c - 3) / 3));
        chk("t1_data", 32'(pix_data), addrs[c-3] & 32'hFFFF);
      end
      chk("t1_grant", 32'(grant), (c <= 8) ? 32'd1 : 32'd0);
      chk("t1_busy",  32'(busy), 32'(c <= 9));
      chk("t1_done",  32'(done), (c == 9) ? 32'd1 : 32'd0);
      if (c == 9) req = '0;
    end

    // Four-way contention, all 1x1
    do_reset();
    for (int i = 0; i < 4; i++) set_geom(i, 12'(16 * i), 12'd0, 12'd1, 12'd1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      wait_grant();
      chk("rr_grant", 32'(grant), 32'(g));
      if (k == 4) req = '0;
      wait_done();
      chk("rr_done", 32'(done), 32'(g));
    end
    tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // Fairness: req2 arrives while req0 is being served
    do_reset();
    set_geom(0, 12'd100, 12'd2, 12'd2, 12'd2);
    set_geom(2, 12'd200, 12'd3, 12'd1, 12'd1);
    req = 4'b0001;
    tick();
    chk("fair_g0", 32'(grant), 32'd1);
    tick();
    req = 4'b0101;
    wait_done();
    chk("fair_d0", 32'(done), 32'd1);
    wait_grant();
    chk("fair_g2", 32'(grant), 32'b0100);
    wait_done();
    chk("fair_d2", 32'(done), 32'b0100);
    wait_grant();
    chk("fair_g0b", 32'(grant), 32'd1);
    req = '0;
    wait_done();
    chk("fair_d0b", 32'(done), 32'd1);

    // Zero-size blits: w=0 on requester 1, then h=0 on requester 3
    do_reset();
    zero_blit(1, 12'd0, 12'd5, 4'b0010);
    zero_blit(3, 12'd3, 12'd0, 4'b1000);

    // Reset in the middle of an 8x8 stream
    do_reset();
    set_geom(0, 12'd0, 12'd0, 12'd8, 12'd8);
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) tick();
    chk("mr_streaming", 32'(rom_en), 32'd1);
    chk("mr_pv_before", 32'(pix_valid), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    tick();
    check_all_zero("mr");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("mr_pv_after", 32'(pix_valid), 32'd0);
      chk("mr_grant_after", 32'(grant), 32'd0);
    end

    // Transparent-key handling on a 4x1 strip over words {0001,F81F,0003,F81F}
    do_reset();
    set_geom(0, 12'd0, 12'd0, 12'd4, 12'd1);
    req = 4'b0001;
    npv = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
`ifdef SPRITE_BLIT_TRANSPARENT_EN
      e_pv = (c == 3) || (c == 5);
`else
      e_pv = (c >= 3) && (c <= 6);
`endif
      chk("tk_pv", 32'(pix_valid), 32'(e_pv));
      if (e_pv) begin
        chk("tk_col",  32'(pix_col), 32'(c - 3));
        chk("tk_data", 32'(pix_data), 32'(rom_fn(24'(c - 3))));
      end
      if (pix_valid) npv++;
      chk("tk_done", 32'(done), (c == 7) ? 32'd1 : 32'd0);
      if (c == 7) req = '0;
    end
`ifdef SPRITE_BLIT_TRANSPARENT_EN
    chk("tk_count", 32'(npv), 32'd2);
`else
    chk("tk_count", 32'(npv), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
